// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared FSM state type and width helpers for the multi-class perceptron
package perceptron_pkg;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  function automatic int acc_w(int in_w, int w_w, int n_in);
    return in_w + w_w + $clog2(n_in + 1) + 1;
  endfunction
  function automatic int bias_idx(int n_in);
    return n_in;
  endfunction
endpackage

// File: rtl/perceptron_if.sv
// perceptron_if: weight-write, feature-in and result-out handshakes; slave = perceptron, master = driver
interface perceptron_if import perceptron_pkg::*; #(
  parameter int N_IN = 2,
  parameter int IN_W = 4,
  parameter int W_W = 4,
  parameter int N_CLASS = 10
);
  localparam int CLS_W = $clog2(N_CLASS);
  localparam int IDX_W = $clog2(N_IN + 1);
  localparam int ACC_W = acc_w(IN_W, W_W, N_IN);
  logic wr_en;
  logic [CLS_W-1:0] wr_class;
  logic [IDX_W-1:0] wr_idx;
  logic [W_W-1:0] wr_data;
  logic wr_ready;
  logic in_valid;
  logic in_ready;
  logic [N_IN*IN_W-1:0] in_feat;
  logic out_valid;
  logic out_ready;
  logic [CLS_W-1:0] out_class;
  logic [ACC_W-1:0] out_score;
  logic busy;
  modport slave (
    input wr_en, wr_class, wr_idx, wr_data, in_valid, in_feat, out_ready,
    output wr_ready, in_ready, out_valid, out_class, out_score, busy
  );
  modport master (
    output wr_en, wr_class, wr_idx, wr_data, in_valid, in_feat, out_ready,
    input wr_ready, in_ready, out_valid, out_class, out_score, busy
  );
endinterface

// File: rtl/perceptron_mac.sv
// perceptron_mac: one signed MAC step (bias or acc + w*x) and strict-greater score compare; i_first picks bias start
module perceptron_mac #(
  parameter int IN_W = 4,
  parameter int W_W = 4,
  parameter int ACC_W = 11
) (
  input  logic                    i_first,
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic signed [W_W-1:0]   i_bias,
  input  logic signed [W_W-1:0]   i_w,
  input  logic        [IN_W-1:0]  i_x,
  input  logic signed [ACC_W-1:0] i_best,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_gt
);
  logic signed [ACC_W-1:0] w_we, w_xe, w_be;
  assign w_we = ACC_W'(i_w);
  assign w_xe = ACC_W'({1'b0, i_x});
  assign w_be = ACC_W'(i_bias);
  assign o_sum = (i_first ? w_be : i_acc) + w_we * w_xe;
  assign o_gt = o_sum > i_best;
endmodule

// File: rtl/perceptron_mc.sv
// perceptron_mc: sequential multi-class perceptron (weight table, one MAC/cycle, argmax); ports clk, rst, bus (perceptron_if.slave)
module perceptron_mc import perceptron_pkg::*; #(
  parameter int N_IN = 2,
  parameter int IN_W = 4,
  parameter int W_W = 4,
  parameter int N_CLASS = 10
) (
  input logic clk,
  input logic rst,
  perceptron_if.slave bus
);
  localparam int CLS_W = $clog2(N_CLASS);
  localparam int IDX_W = $clog2(N_IN + 1);
  localparam int ACC_W = acc_w(IN_W, W_W, N_IN);
  localparam int BI = bias_idx(N_IN);
  state_t r_state, w_next;
  logic signed [W_W-1:0] r_w [N_CLASS][N_IN+1];
  logic [N_IN*IN_W-1:0] r_x;
  logic [CLS_W-1:0] r_c, r_bc, r_oc;
  logic [IDX_W-1:0] r_i;
  logic signed [ACC_W-1:0] r_acc, r_best, r_os, w_sum;
  logic signed [W_W-1:0] w_wt;
  logic [IN_W-1:0] w_x;
  logic w_gt, w_last, w_take, w_wr, w_acc;
  assign w_acc = r_state == IDLE && bus.in_valid;
  assign w_wr = r_state == IDLE && bus.wr_en && int'(bus.wr_class) < N_CLASS && int'(bus.wr_idx) <= N_IN;
  assign w_last = r_state == MAC && int'(r_i) == N_IN - 1;
  assign w_take = w_last && (r_c == '0 || w_gt);
  always_comb begin
    w_x = '0;
    w_wt = '0;
    for (int k = 0; k < N_IN; k++)
      if (int'(r_i) == k) begin
        w_x = r_x[k*IN_W +: IN_W];
        w_wt = r_w[r_c][k];
      end
  end
  perceptron_mac #(.IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W)) u_mac (
    .i_first(r_i == '0),
    .i_acc(r_acc),
    .i_bias(r_w[r_c][BI]),
    .i_w(w_wt),
    .i_x(w_x),
    .i_best(r_best),
    .o_sum(w_sum),
    .o_gt(w_gt)
  );
  always_comb begin
    w_next = r_state;
    if (w_acc) w_next = MAC;
    if (w_last && int'(r_c) == N_CLASS - 1) w_next = DONE;
    if (r_state == DONE && bus.out_ready) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int a = 0; a < N_CLASS; a++)
        for (int b = 0; b <= N_IN; b++) r_w[a][b] <= '0;
      r_x <= '0;
      r_c <= '0;
      r_i <= '0;
      r_acc <= '0;
      r_best <= '0;
      r_bc <= '0;
      r_oc <= '0;
      r_os <= '0;
    end else begin
      if (w_wr) r_w[bus.wr_class][bus.wr_idx] <= bus.wr_data;
      if (w_acc) begin
        r_x <= bus.in_feat;
        r_c <= '0;
        r_i <= '0;
      end
      if (r_state == MAC) begin
        r_acc <= w_sum;
        r_i <= w_last ? '0 : r_i + 1'b1;
        if (w_last && w_next != DONE) r_c <= r_c + 1'b1;
        if (w_take) begin
          r_best <= w_sum;
          r_bc <= r_c;
        end
        // output registers load only on the final step so they hold through the next inference
        if (w_next == DONE) begin
          r_oc <= w_take ? r_c : r_bc;
          r_os <= w_take ? w_sum : r_best;
        end
      end
    end
  assign bus.wr_ready = r_state == IDLE;
  assign bus.in_ready = r_state == IDLE;
  assign bus.busy = r_state != IDLE;
  assign bus.out_valid = r_state == DONE;
  assign bus.out_class = r_oc;
  assign bus.out_score = r_os;
endmodule

// File: tb/tb_perceptron_mc.sv
// tb_perceptron_mc: randomized and directed checks of perceptron_mc against a cycle-level behavioural model
module tb_perceptron_mc;
  localparam int N_IN = 2, IN_W = 4, W_W = 4, N_CLASS = 10;
  localparam int CLS_W = $clog2(N_CLASS), IDX_W = $clog2(N_IN + 1);
  localparam int LAT = N_CLASS * N_IN;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  perceptron_if #(.N_IN(N_IN), .IN_W(IN_W), .W_W(W_W), .N_CLASS(N_CLASS)) bus ();
  perceptron_mc #(.N_IN(N_IN), .IN_W(IN_W), .W_W(W_W), .N_CLASS(N_CLASS)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0, n_bad = 0;
  int mw [N_CLASS][N_IN+1];
  int m_phase = 0, m_cnt = 0, m_cls = 0, m_sc = 0, p_cls = 0, p_sc = 0;
  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic score(logic [N_IN*IN_W-1:0] f);
    int s;
    for (int c = 0; c < N_CLASS; c++) begin
      s = mw[c][N_IN];
      for (int i = 0; i < N_IN; i++) s += mw[c][i] * int'(f[i*IN_W +: IN_W]);
      if (c == 0 || s > p_sc) begin
        p_sc = s;
        p_cls = c;
      end
    end
  endtask
  // phase: 0 idle, 1 computing (m_cnt cycles left), 2 result held
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_phase = 0;
      m_cls = 0;
      m_sc = 0;
      foreach (mw[a, b]) mw[a][b] = 0;
    end else if (m_phase == 0) begin
      if (bus.wr_en && int'(bus.wr_class) < N_CLASS && int'(bus.wr_idx) <= N_IN)
        mw[bus.wr_class][bus.wr_idx] = int'($signed(bus.wr_data));
      if (bus.in_valid) begin
        score(bus.in_feat);
        m_cnt = LAT;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_phase = 2;
        m_cls = p_cls;
        m_sc = p_sc;
      end
    end else if (bus.out_ready) m_phase = 0;
  always @(negedge clk) begin
    chk("out_valid", int'(bus.out_valid), int'(m_phase == 2));
    chk("in_ready", int'(bus.in_ready), int'(m_phase == 0));
    chk("wr_ready", int'(bus.wr_ready), int'(m_phase == 0));
    chk("busy", int'(bus.busy), int'(m_phase != 0));
    chk("out_class", int'(bus.out_class), m_cls);
    chk("out_score", int'($signed(bus.out_score)), m_sc);
  end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic wr(int c, int i, int d);
    bus.wr_en = 1;
    bus.wr_class = CLS_W'(c);
    bus.wr_idx = IDX_W'(i);
    bus.wr_data = W_W'(d);
    tick;
    bus.wr_en = 0;
  endtask
  task automatic set_all(int w, int b);
    for (int c = 0; c < N_CLASS; c++)
      for (int i = 0; i <= N_IN; i++) wr(c, i, i == N_IN ? b : w);
  endtask
  task automatic do_reset;
    rst = 1;
    tick;
    rst = 0;
  endtask
  task automatic infer(int x0, int x1, int ec, int es, int hold);
    int k = 0;
    bus.in_feat = {IN_W'(x1), IN_W'(x0)};
    bus.in_valid = 1;
    tick;
    bus.in_valid = 0;
    while (!bus.out_valid && k < 100) begin
      tick;
      k++;
    end
    chk("latency", k, LAT);
    chk("lit_class", int'(bus.out_class), ec);
    chk("lit_score", int'($signed(bus.out_score)), es);
    for (int h = 0; h < hold; h++) begin
      bus.wr_en = 1;
      bus.wr_class = '0;
      bus.wr_idx = '0;
      bus.wr_data = W_W'(7);
      bus.in_valid = 1;
      tick;
      chk("bp_class", int'(bus.out_class), ec);
      chk("bp_score", int'($signed(bus.out_score)), es);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_valid", int'(bus.out_valid), 1);
    end
    bus.wr_en = 0;
    bus.in_valid = 0;
    bus.out_ready = 1;
    tick;
    bus.out_ready = 0;
    chk("post_valid", int'(bus.out_valid), 0);
    chk("post_in_ready", int'(bus.in_ready), 1);
  endtask
  initial begin
    bus.wr_en = 0;
    bus.wr_class = '0;
    bus.wr_idx = '0;
    bus.wr_data = '0;
    bus.in_valid = 0;
    bus.in_feat = '0;
    bus.out_ready = 0;
    repeat (2) tick;
    rst = 0;
    tick;
    wr(3, 0, 2);
    wr(3, 1, 1);
    infer(5, 4, 3, 14, 0);
    bus.in_feat = {IN_W'(4), IN_W'(5)};
    bus.in_valid = 1;
    tick;
    bus.in_valid = 0;
    repeat (7) tick;
    rst = 1;
    tick;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    rst = 0;
    tick;
    infer(5, 4, 0, 0, 0);
    set_all(0, -8);
    wr(7, N_IN, -1);
    infer(15, 15, 7, -1, 0);
    do_reset;
    wr(2, 0, 3);
    wr(6, 0, 3);
    infer(4, 9, 2, 12, 10);
    infer(4, 9, 2, 12, 0);
    set_all(7, 7);
    infer(15, 15, 0, 217, 0);
    set_all(-8, -8);
    infer(15, 15, 0, -248, 0);
    for (int n = 0; n < 4000; n++) begin
      bus.wr_en = $urandom_range(0, 2) == 0;
      bus.wr_class = CLS_W'($urandom_range(0, 15));
      bus.wr_idx = IDX_W'($urandom_range(0, 3));
      bus.wr_data = W_W'($urandom);
      bus.in_valid = $urandom_range(0, 5) == 0;
      bus.in_feat = (N_IN*IN_W)'($urandom);
      bus.out_ready = $urandom_range(0, 2) != 0;
      rst = $urandom_range(0, 999) == 0;
      tick;
    end
    rst = 0;
    bus.wr_en = 0;
    bus.in_valid = 0;
    bus.out_ready = 1;
    repeat (3) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
